// File: rtl/fc_act_loader_if.sv
// Stream-in / vector-out bundle between an activation source, fc_act_loader and the FC layer.
// The loader sits on the slave modport; the activation source and result capture use master.
interface fc_act_loader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128
);
  logic                      s_valid;
  logic                      s_ready;
  logic [WIDTH-1:0]          s_data;
  logic                      s_last;
  logic [IN-1:0][WIDTH-1:0]  x;
  logic                      x_valid;
  logic                      x_ack;
  logic                      err_len;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output x_ack,
    input  s_ready,
    input  x,
    input  x_valid,
    input  err_len
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  x_ack,
    output s_ready,
    output x,
    output x_valid,
    output err_len
  );
endinterface

// File: rtl/fc_act_loader.sv
// Assembles IN streamed activations into a registered vector held for the FC layer until acked.
// Define LOADER_ZPAD_EN to zero-pad short vectors instead of flagging and discarding them.
module fc_act_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128
) (
  input logic             clk,
  input logic             rst_n,
  fc_act_loader_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(IN);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(IN - 1);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IN-1:0][WIDTH-1:0]  buf_q, buf_d;
  logic                      err_q, err_d;
  logic                      s_ready;
  logic                      x_valid;
  logic                      accept;
  logic                      at_end;

  assign accept = bus.s_valid && s_ready;
  assign at_end = (idx_q == LastIdx);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      idx_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (at_end) begin
            // Overlong vectors still complete; only the missing s_last is flagged.
            state_d = StFull;
            idx_d   = '0;
            err_d   = !bus.s_last;
          end else if (bus.s_last) begin
`ifdef LOADER_ZPAD_EN
            state_d = StFull;
            idx_d   = '0;
`else
            idx_d   = '0;
            err_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StFull: begin
        if (bus.x_ack) begin
          state_d = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // Vector buffer write; x is taken straight from the buffer.
  always_comb begin
    buf_d = buf_q;
    if (accept) begin
      buf_d[idx_q] = bus.s_data;
`ifdef LOADER_ZPAD_EN
      if (bus.s_last && !at_end) begin
        for (int unsigned i = 0; i < IN; i++) begin
          if (i > 32'(idx_q)) begin
            buf_d[i] = '0;
          end
        end
      end
`endif
    end
  end

  // Outputs; s_ready is forced low while reset is asserted.
  always_comb begin
    s_ready = 1'b0;
    x_valid = 1'b0;
    unique case (state_q)
      StFill:  s_ready = rst_n;
      StFull:  x_valid = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign bus.s_ready = s_ready;
  assign bus.x_valid = x_valid;
  assign bus.x       = buf_q;
  assign bus.err_len = err_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// Self-checking bench for fc_act_loader: directed cases plus randomized vectors vs a vector model.
module tb_fc_act_loader;
  localparam int unsigned W = 8;
  localparam int unsigned N = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_act_loader_if #(.WIDTH(W), .IN(N)) bus ();

  fc_act_loader #(.WIDTH(W), .IN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp   = 0;
  int n_err   = 0;
  int err_cnt = 0;
  logic auto_ack = 1'b0;
  logic ack_req  = 1'b0;
  int   ack_cnt  = 0;

  logic [W-1:0]         vec_d [N];
  logic [N-1:0][W-1:0]  exp_v;

  always @(posedge clk) begin
    if (bus.err_len === 1'b1) err_cnt <= err_cnt + 1;
  end

  // Sole driver of x_ack: directed requests, or random ack delays plus stray acks during fill.
  initial begin
    bus.x_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_ack && bus.x_valid) begin
        if (ack_cnt == 0) begin
          bus.x_ack = 1'b1;
          ack_cnt   = int'($urandom_range(0, 5));
        end else begin
          bus.x_ack = 1'b0;
          ack_cnt--;
        end
      end else begin
        bus.x_ack = ack_req || (auto_ack && ($urandom_range(0, 3) == 0));
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) begin
      check("beat_timeout", bus.s_ready, 1'b1);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_vec(input int len, input logic mark_last, input int gap_max);
    int g;
    for (int i = 0; i < len; i++) begin
      g = 0;
      if (gap_max > 0 && $urandom_range(0, 3) == 0) g = int'($urandom_range(1, gap_max));
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      beat(vec_d[i], mark_last && (i == len - 1));
    end
  endtask

  task automatic rand_vec();
    for (int i = 0; i < N; i++) vec_d[i] = W'($urandom);
  endtask

  // Expected layer input: the first len beats as sent, zeros beyond.
  task automatic build_exp(input int len);
    for (int i = 0; i < N; i++) exp_v[i] = (i < len) ? vec_d[i] : '0;
  endtask

  task automatic do_ack(input string tag);
    ack_req = 1'b1;
    @(posedge clk);
    #1;
    ack_req = 1'b0;
    check({tag, "_ack_xv"}, bus.x_valid, 1'b0);
    check({tag, "_ack_rdy"}, bus.s_ready, 1'b1);
  endtask

  initial begin
    int e0;
    int rdy_seen;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", bus.s_ready, 1'b0);
    check("rst_xv", bus.x_valid, 1'b0);
    check("rst_err", bus.err_len, 1'b0);
    check("rst_x", bus.x, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_rdy", bus.s_ready, 1'b1);

    // Ramp vector
    for (int i = 0; i < N; i++) vec_d[i] = W'(i);
    e0 = err_cnt;
    send_vec(N, 1'b1, 0);
    build_exp(N);
    check("t1_xv", bus.x_valid, 1'b1);
    check("t1_x", bus.x, exp_v);
    check("t1_rdy", bus.s_ready, 1'b0);

    // Hold in FULL with s_valid asserted
    rdy_seen = 0;
    bus.s_valid = 1'b1;
    repeat (50) begin
      bus.s_data = W'($urandom);
      @(posedge clk);
      #1;
      if (bus.s_ready === 1'b1) rdy_seen++;
    end
    bus.s_valid = 1'b0;
    check("t2_x_hold", bus.x, exp_v);
    check("t2_rdy_seen", rdy_seen, 0);
    check("t2_xv", bus.x_valid, 1'b1);
    check("t1_err_cnt", err_cnt - e0, 0);
    do_ack("t2");

    // Overlong vector, then a clean one
    rand_vec();
    e0 = err_cnt;
    send_vec(N, 1'b0, 0);
    build_exp(N);
    check("t3_err_now", bus.err_len, 1'b1);
    check("t3_xv", bus.x_valid, 1'b1);
    check("t3_x", bus.x, exp_v);
    repeat (3) @(posedge clk);
    #1;
    check("t3_err_cnt", err_cnt - e0, 1);
    do_ack("t3");
    rand_vec();
    send_vec(N, 1'b1, 0);
    build_exp(N);
    check("t3b_x", bus.x, exp_v);
    check("t3b_xv", bus.x_valid, 1'b1);
    do_ack("t3b");

    // Short vector
    for (int i = 0; i < 10; i++) vec_d[i] = 8'h7F;
    e0 = err_cnt;
    send_vec(10, 1'b1, 0);
`ifdef LOADER_ZPAD_EN
    build_exp(10);
    check("t4_xv", bus.x_valid, 1'b1);
    check("t4_x", bus.x, exp_v);
    check("t4_err_now", bus.err_len, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_err_cnt", err_cnt - e0, 0);
    do_ack("t4");
`else
    check("t4_err_now", bus.err_len, 1'b1);
    check("t4_xv", bus.x_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t4_err_drop", bus.err_len, 1'b0);
    check("t4_xv_late", bus.x_valid, 1'b0);
    check("t4_err_cnt", err_cnt - e0, 1);
    rand_vec();
    send_vec(N, 1'b1, 0);
    build_exp(N);
    check("t4b_xv", bus.x_valid, 1'b1);
    check("t4b_x", bus.x, exp_v);
    do_ack("t4b");
`endif

    // Asynchronous reset mid-fill
    rand_vec();
    send_vec(60, 1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rdy", bus.s_ready, 1'b0);
    check("t5_xv", bus.x_valid, 1'b0);
    check("t5_err", bus.err_len, 1'b0);
    check("t5_x", bus.x, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_vec();
    send_vec(N, 1'b1, 0);
    build_exp(N);
    check("t5b_xv", bus.x_valid, 1'b1);
    check("t5b_x", bus.x, exp_v);
    do_ack("t5b");

    // Randomized gaps and ack delays
    auto_ack = 1'b1;
    e0 = err_cnt;
    for (int v = 0; v < 250; v++) begin
      rand_vec();
      send_vec(N, 1'b1, 3);
      build_exp(N);
      check("t6_xv", bus.x_valid, 1'b1);
      check("t6_x", bus.x, exp_v);
    end
    repeat (20) @(posedge clk);
    #1;
    check("t6_drain_xv", bus.x_valid, 1'b0);
    check("t6_err_cnt", err_cnt - e0, 0);
    auto_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
